// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Purpose : Two-port arbiter/sequencer in front of a single-ported data
//           memory. Holds strobes for MEM_LAT cycles, then pulses one ack.
// Option  : define DMEM_ARB_RR_EN for round-robin tie-breaking
//           (default build: fixed priority, port 0 wins ties).
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,

  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,

  output logic              busy_o,
  output logic              grant_o
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_DONE   = 2'd2;

  localparam logic [3:0] c_LAT_M1 = 4'(MEM_LAT - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic              r_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic w_any_req;
  logic w_sel1;
  logic w_access;
  logic w_done;

  assign w_any_req = m0_req_i | m1_req_i;

`ifdef DMEM_ARB_RR_EN
  // Last-grant pointer starts at 1 so the very first tie goes to port 0.
  logic r_last;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_last <= 1'b1;
    end else if (r_state == c_IDLE && w_any_req) begin
      r_last <= w_sel1;
    end
  end

  assign w_sel1 = m1_req_i & (~m0_req_i | ~r_last);
`else
  assign w_sel1 = m1_req_i & ~m0_req_i;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_grant <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_sel1;
            r_we    <= w_sel1 ? m1_we_i    : m0_we_i;
            r_addr  <= w_sel1 ? m1_addr_i  : m0_addr_i;
            r_wdata <= w_sel1 ? m1_wdata_i : m0_wdata_i;
            r_cnt   <= c_LAT_M1;
            r_state <= c_ACCESS;
          end
        end
        c_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= c_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Read data is captured on the final ACCESS edge, only into the owner's port.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (r_state == c_ACCESS && r_cnt == 4'd0 && !r_we) begin
      if (r_grant) begin
        r_rdata1 <= mem_rdata_i;
      end else begin
        r_rdata0 <= mem_rdata_i;
      end
    end
  end

  assign w_access = (r_state == c_ACCESS);
  assign w_done   = (r_state == c_DONE);

  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_write_o = w_access &  r_we;
  assign mem_read_o  = w_access & ~r_we;

  assign m0_ack_o   = w_done & ~r_grant;
  assign m1_ack_o   = w_done &  r_grant;
  assign m0_rdata_o = r_rdata0;
  assign m1_rdata_o = r_rdata1;

  assign busy_o  = w_access | w_done;
  assign grant_o = r_grant;

endmodule
`default_nettype wire
